// File: rtl/tug_player_input.sv
// Tug of War player front end: sync, debounce and one-shot each raw key into L/R move pulses.
// Latency: press first sampled on edge 1 -> pulse in the cycle after edge DEBOUNCE_CYCLES+3; no backpressure.
module tug_player_input #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic game_over,
    output logic L,
    output logic R
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_REL
    } state_t;

    // Index 0 is the left key, index 1 the right key; internal level 1 = pressed.
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_db;
    logic [1:0]       w_db_nxt;
    logic [CNT_W-1:0] r_cnt     [2];
    logic [CNT_W-1:0] w_cnt_nxt [2];
    state_t           r_state   [2];
    state_t           w_state_nxt [2];
    logic [1:0]       w_req;

    assign w_raw = {~key_r_n, ~key_l_n};

    // The synchronizer keeps sampling through reset so a key held across reset
    // is already visible as pressed afterwards and cannot be mistaken for a new press.
    always_ff @(posedge clk) begin
        r_sync1 <= w_raw;
        r_sync2 <= r_sync1;
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_db_nxt[k]  = r_db[k];
            w_cnt_nxt[k] = '0;
            if (r_sync2[k] != r_db[k]) begin
                if (r_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_db_nxt[k] = r_sync2[k];
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // The FSM follows the next debounced level so FIRE coincides with db rising,
    // which places the registered pulse right after edge DEBOUNCE_CYCLES+3.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_state_nxt[k] = r_state[k];
            w_req[k]       = 1'b0;
            case (r_state[k])
                S_IDLE: begin
                    if (w_db_nxt[k]) begin
                        w_state_nxt[k] = S_FIRE;
                    end
                end
                S_FIRE: begin
                    w_req[k]       = 1'b1;
                    w_state_nxt[k] = S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!w_db_nxt[k] && !r_sync2[k]) begin
                        w_state_nxt[k] = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[k] = S_WAIT_REL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_db <= 2'b00;
            L    <= 1'b0;
            R    <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                r_cnt[k]   <= '0;
                r_state[k] <= S_WAIT_REL;
            end
        end else begin
            r_db <= w_db_nxt;
            L    <= w_req[0] & ~w_req[1] & ~game_over;
            R    <= w_req[1] & ~w_req[0] & ~game_over;
            for (int k = 0; k < 2; k++) begin
                r_cnt[k]   <= w_cnt_nxt[k];
                r_state[k] <= w_state_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_tug_player_input.sv
// Bench for tug_player_input: directed test-plan steps followed by random key/game_over/reset traffic,
// every cycle compared against a window-based reference model of the key rules.
module tb_tug_player_input;

    localparam int D    = 4;
    localparam int MAXE = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_l_n = 1'b1;
    logic key_r_n = 1'b1;
    logic game_over = 1'b0;
    logic L;
    logic R;

    int n_cmp = 0;
    int n_fail = 0;
    int pulses_l = 0;
    int pulses_r = 0;

    // Reference model state
    int e = 0;
    int last_rst = -1;
    bit rawh [2][0:MAXE-1];
    bit db [2];
    bit armed [2];
    bit req [2];
    bit exp_l = 1'b0;
    bit exp_r = 1'b0;

    tug_player_input #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_l_n   (key_l_n),
        .key_r_n   (key_r_n),
        .game_over (game_over),
        .L         (L),
        .R         (R)
    );

    always #5 clk = ~clk;

    // Synchronized level seen just before edge m: raw level sampled two edges earlier.
    function automatic bit sb(input int k, input int m);
        if (m < 2) return 1'b0;
        return rawh[k][m-2];
    endfunction

    task automatic model_edge();
        bit want, ok, rose;
        if (e < MAXE) begin
            rawh[0][e] = !key_l_n;
            rawh[1][e] = !key_r_n;
        end
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                db[k] = 1'b0; armed[k] = 1'b0; req[k] = 1'b0;
            end
            exp_l = 1'b0;
            exp_r = 1'b0;
            last_rst = e;
        end else begin
            exp_l = req[0] & !req[1] & !game_over;
            exp_r = req[1] & !req[0] & !game_over;
            for (int k = 0; k < 2; k++) begin
                // Debounced level flips once the last D synchronized samples since reset all disagree with it.
                want = !db[k];
                ok = 1'b1;
                for (int m = e - D + 1; m <= e; m++) begin
                    if (m <= last_rst || sb(k, m) != want) ok = 1'b0;
                end
                rose = 1'b0;
                if (ok) begin
                    db[k] = want;
                    rose = want;
                end
                req[k] = 1'b0;
                if (armed[k] && rose) begin
                    req[k] = 1'b1;
                    armed[k] = 1'b0;
                end else if (!armed[k] && !db[k] && !sb(k, e)) begin
                    armed[k] = 1'b1;
                end
            end
        end
        e++;
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b (edge %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic check_cnt(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs == expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("L_model", L, exp_l);
        check("R_model", R, exp_r);
        check("L_R_exclusive", L & R, 1'b0);
        if (L === 1'b1) pulses_l++;
        if (R === 1'b1) pulses_r++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int rem_l, rem_r;

    initial begin
        // T1: reset, then press left from edge 1
        steps(2);
        check("reset_L", L, 1'b0);
        check("reset_R", R, 1'b0);
        reset = 1'b0;
        key_l_n = 1'b0;
        pulses_l = 0;
        steps(6);
        check("t1_before_edge7", L, 1'b0);
        step();
        check("t1_edge7_L", L, 1'b1);
        step();
        check("t1_edge8_L", L, 1'b0);

        // T2: held 40 cycles total -> one pulse; release, re-press -> same latency
        steps(32);
        check_cnt("t2_hold_pulses", pulses_l, 1);
        key_l_n = 1'b1;
        steps(10);
        key_l_n = 1'b0;
        steps(6);
        check("t2_repress_before", L, 1'b0);
        step();
        check("t2_repress_edge7", L, 1'b1);
        steps(10);
        key_l_n = 1'b1;
        steps(15);

        // T3: 3-cycle glitch on right key
        pulses_r = 0;
        key_r_n = 1'b0;
        steps(3);
        key_r_n = 1'b1;
        steps(15);
        check_cnt("t3_glitch_pulses", pulses_r, 0);

        // T4: simultaneous presses, then right alone
        pulses_l = 0; pulses_r = 0;
        key_l_n = 1'b0; key_r_n = 1'b0;
        steps(20);
        check_cnt("t4_both_L", pulses_l, 0);
        check_cnt("t4_both_R", pulses_r, 0);
        key_l_n = 1'b1; key_r_n = 1'b1;
        steps(12);
        key_r_n = 1'b0;
        steps(20);
        check_cnt("t4_r_alone", pulses_r, 1);
        check_cnt("t4_l_none", pulses_l, 0);
        key_r_n = 1'b1;
        steps(12);

        // T5: press during game_over, no replay after it drops
        pulses_l = 0;
        game_over = 1'b1;
        key_l_n = 1'b0;
        steps(20);
        check_cnt("t5_gameover", pulses_l, 0);
        game_over = 1'b0;
        steps(20);
        check_cnt("t5_no_replay", pulses_l, 0);
        key_l_n = 1'b1;
        steps(12);
        key_l_n = 1'b0;
        steps(6);
        step();
        check("t5_repress_edge7", L, 1'b1);
        steps(5);
        key_l_n = 1'b1;
        steps(12);

        // T6: key held across reset
        key_l_n = 1'b0;
        steps(12);
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        pulses_l = 0;
        steps(20);
        check_cnt("t6_held_reset", pulses_l, 0);
        key_l_n = 1'b1;
        steps(10);
        key_l_n = 1'b0;
        steps(6);
        check("t6_before_edge7", L, 1'b0);
        step();
        check("t6_edge7_L", L, 1'b1);
        steps(5);
        key_l_n = 1'b1;
        steps(12);

        // Random traffic
        rem_l = 0; rem_r = 0;
        for (int i = 0; i < 1500; i++) begin
            if (rem_l == 0) begin
                key_l_n = 1'($urandom_range(0, 1));
                rem_l = $urandom_range(1, 12);
            end
            if (rem_r == 0) begin
                key_r_n = 1'($urandom_range(0, 1));
                rem_r = $urandom_range(1, 12);
            end
            rem_l--; rem_r--;
            if ($urandom_range(0, 39) == 0) game_over = ~game_over;
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        steps(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
